// File: rtl/edge_det_if.sv
// ---------------------------------------------------------------------------
// edge_det_if
// Bundles the data-side signals of the edge_det block so that a parent or a
// bench can carry them as one object. Clock and reset stay outside the
// bundle and are wired as plain signals.
//
//   sig_in    raw, possibly asynchronous monitored bits    (master -> slave)
//   en        detection enable                             (master -> slave)
//   sig_sync  synchronized copy of sig_in                  (slave -> master)
//   rise      per-bit one-cycle rising-edge pulse          (slave -> master)
//   fall      per-bit one-cycle falling-edge pulse         (slave -> master)
//   any_edge  rise | fall                                  (slave -> master)
// ---------------------------------------------------------------------------
interface edge_det_if #(
   parameter int WIDTH = 1
) ();

   logic [WIDTH-1:0] sig_in;
   logic             en;
   logic [WIDTH-1:0] sig_sync;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] any_edge;

   // The master drives the monitored bits and the enable.
   modport master (
      output sig_in,
      output en,
      input  sig_sync,
      input  rise,
      input  fall,
      input  any_edge
   );

   // The slave is the detector itself.
   modport slave (
      input  sig_in,
      input  en,
      output sig_sync,
      output rise,
      output fall,
      output any_edge
   );

endinterface

// File: rtl/edge_det.sv
// ---------------------------------------------------------------------------
// edge_det
// Per-bit synchronizer followed by rising/falling edge detection. Every bit
// is handled independently; nothing crosses between bits.
//
// Parameters
//   WIDTH        number of monitored bits (1..32)
//   SYNC_STAGES  synchronizer depth ahead of detection (0..4, 0 = bypass)
//   RESET_VAL    value loaded into every synchronizer and history flop
//
// Ports
//   clk       in   1      rising-edge clock
//   n_rst     in   1      asynchronous active-low reset
//   sig_in    in   WIDTH  raw monitored bits (defaults to all zero)
//   en        in   1      detection enable (defaults to 1)
//   sig_sync  out  WIDTH  synchronized copy of sig_in
//   rise      out  WIDTH  one-cycle pulse on a 0->1 change of sig_sync
//   fall      out  WIDTH  one-cycle pulse on a 1->0 change of sig_sync
//   any_edge  out  WIDTH  rise | fall
// ---------------------------------------------------------------------------
module edge_det #(
   parameter int   WIDTH       = 1,
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] sig_in = '0,
   input  logic             en     = 1'b1,
   output logic [WIDTH-1:0] sig_sync,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] any_edge
);

   localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VAL}};

   // Value of sig_sync one clock ago; the edge is the difference between
   // this and the current synchronized value.
   logic [WIDTH-1:0] prev_q;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         // No synchronizer: the caller guarantees sig_in is already in the
         // clk domain, so detection works on the raw input.
         assign sig_sync = sig_in;
      end else begin : g_sync
         logic [WIDTH-1:0] sync_q [SYNC_STAGES];

         // Synchronizer chain: stage 0 captures the raw input, each later
         // stage copies its predecessor. Reset forces every stage to the
         // reset value so no edge can be seen from stale pre-reset data.
         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= RST_VEC;
               end
            end else begin
               sync_q[0] <= sig_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign sig_sync = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // History flop tracks sig_sync every cycle even while detection is
   // disabled, so an edge that happens with en low is consumed and never
   // reported later.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_q <= RST_VEC;
      end else begin
         prev_q <= sig_sync;
      end
   end

   // Edge decode. The enable masks the outputs only; rise and fall are
   // mutually exclusive because they need opposite values of sig_sync.
   always_comb begin
      rise     = {WIDTH{en}} &  sig_sync & ~prev_q;
      fall     = {WIDTH{en}} & ~sig_sync &  prev_q;
      any_edge = rise | fall;
   end

endmodule

// File: tb/tb_edge_det.sv
// ---------------------------------------------------------------------------
// tb_edge_det
// Self-checking bench for edge_det (WIDTH=4, SYNC_STAGES=2). A log of the
// sig_in values captured at each clock edge since reset acts as the
// reference: sig_sync is the value captured SYNC edges ago, the history is
// the value captured SYNC+1 edges ago, and edges follow from those two.
// ---------------------------------------------------------------------------
module tb_edge_det;

   localparam int W    = 4;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic n_rst;

   edge_det_if #(.WIDTH(W)) dif ();

   edge_det #(
      .WIDTH       (W),
      .SYNC_STAGES (SYNC),
      .RESET_VAL   (1'b0)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .sig_in   (dif.sig_in),
      .en       (dif.en),
      .sig_sync (dif.sig_sync),
      .rise     (dif.rise),
      .fall     (dif.fall),
      .any_edge (dif.any_edge)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int riseCount;
   int fallCount;
   int anyCount;

   // Reference log: every value of sig_in seen at a clock edge since the
   // last reset, oldest first. Reset wipes it.
   logic [W-1:0] sampleLog [$];

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sampleLog.delete();
      end else begin
         sampleLog.push_back(dif.sig_in);
      end
   end

   // Value captured 'back' edges ago, or the reset value if that edge has
   // not happened since reset.
   function automatic logic [W-1:0] modelSample(int back);
      int n;
      n = sampleLog.size();
      if (n >= back) begin
         return sampleLog[n-back];
      end
      return '0;
   endfunction

   // Single comparison point for vector values.
   task automatic checkVal(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Single comparison point for counts.
   task automatic checkInt(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compare every output against the reference log.
   task automatic checkOutput(string tag);
      logic [W-1:0] s;
      logic [W-1:0] p;
      logic [W-1:0] r;
      logic [W-1:0] f;
      s = modelSample(SYNC);
      p = modelSample(SYNC + 1);
      r = (dif.en === 1'b1) ? (s & ~p) : '0;
      f = (dif.en === 1'b1) ? (~s & p) : '0;
      checkVal({tag, ".sync"}, dif.sig_sync, s);
      checkVal({tag, ".rise"}, dif.rise, r);
      checkVal({tag, ".fall"}, dif.fall, f);
      checkVal({tag, ".any"},  dif.any_edge, r | f);
      checkVal({tag, ".excl"}, dif.rise & dif.fall, '0);
   endtask

   // Advance to the next falling edge, check, and tally pulses.
   task automatic applyStimulus(string tag);
      @(negedge clk);
      checkOutput(tag);
      if (dif.rise != '0)     riseCount++;
      if (dif.fall != '0)     fallCount++;
      if (dif.any_edge != '0) anyCount++;
   endtask

   task automatic clearCounts();
      riseCount = 0;
      fallCount = 0;
      anyCount  = 0;
   endtask

   // Directed scenarios first, then a randomized soak.
   initial begin
      n_rst      = 1'b0;
      dif.sig_in = '0;
      dif.en     = 1'b1;
      clearCounts();

      // Reset held two cycles, released on a falling edge, input quiet.
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (10) applyStimulus("reset");
      checkInt("reset.rises", riseCount, 0);
      checkInt("reset.falls", fallCount, 0);
      checkVal("reset.syncval", dif.sig_sync, 4'b0000);

      // Rise latency: change before edge k, pulse between k+1 and k+2.
      clearCounts();
      dif.sig_in = 4'b0001;
      applyStimulus("lat");
      checkVal("lat.k", dif.rise, 4'b0000);
      applyStimulus("lat");
      checkVal("lat.k1", dif.rise, 4'b0001);
      applyStimulus("lat");
      checkVal("lat.k2", dif.rise, 4'b0000);
      checkInt("lat.falls", fallCount, 0);

      // Fall and hold for 20 cycles: one fall pulse only.
      clearCounts();
      dif.sig_in = 4'b0000;
      repeat (20) applyStimulus("hold");
      checkInt("hold.falls", fallCount, 1);
      checkInt("hold.rises", riseCount, 0);
      checkInt("hold.any", anyCount, 1);

      // One-cycle input pulse: rise then fall on consecutive cycles.
      dif.sig_in = 4'b0001;
      applyStimulus("narrow");
      dif.sig_in = 4'b0000;
      applyStimulus("narrow");
      checkVal("narrow.rise", dif.rise, 4'b0001);
      applyStimulus("narrow");
      checkVal("narrow.fall", dif.fall, 4'b0001);
      repeat (3) applyStimulus("narrow");

      // Glitch between clock edges: never sampled, never reported.
      clearCounts();
      #1 dif.sig_in = 4'b1111;
      #2 dif.sig_in = 4'b0000;
      repeat (5) applyStimulus("glitch");
      checkInt("glitch.any", anyCount, 0);

      // Edge during en=0 is dropped, not deferred.
      clearCounts();
      dif.en     = 1'b0;
      dif.sig_in = 4'b0001;
      repeat (5) applyStimulus("mask");
      dif.en = 1'b1;
      repeat (5) applyStimulus("mask");
      checkInt("mask.rises", riseCount, 0);
      checkVal("mask.sync", dif.sig_sync, 4'b0001);

      // Multi-bit simultaneous edges, then reset in the middle of the pulse.
      dif.sig_in = 4'b0000;
      repeat (4) applyStimulus("multi");
      dif.sig_in = 4'b1010;
      applyStimulus("multi");
      applyStimulus("multi");
      checkVal("multi.rise", dif.rise, 4'b1010);
      #2 n_rst = 1'b0;
      #1;
      checkVal("midrst.rise", dif.rise, 4'b0000);
      checkVal("midrst.any", dif.any_edge, 4'b0000);
      checkVal("midrst.sync", dif.sig_sync, 4'b0000);
      checkOutput("midrst");
      @(negedge clk);
      n_rst = 1'b1;

      // Input differs from reset value at release: exactly one pulse.
      clearCounts();
      repeat (6) applyStimulus("postrst");
      checkInt("postrst.rises", riseCount, 1);
      checkInt("postrst.falls", fallCount, 0);

      // Randomized soak with sparse enable drops and occasional resets.
      for (int i = 0; i < 400; i++) begin
         dif.sig_in = W'($urandom);
         dif.en     = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 49) == 0) begin
            #2 n_rst = 1'b0;
            #1 checkOutput("rnd.rst");
            @(negedge clk);
            n_rst = 1'b1;
         end
         applyStimulus("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/edge_det.md
EDGE_DET -- requirements
Module: edge_det

Interface
REQ-001 Parameter WIDTH, default 1: number of independent monitored bits (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth ahead of detection (0..4); 0 = input used directly.
REQ-003 Parameter RESET_VAL, default 1'b0: per-bit value loaded into every synchronizer and history flop on reset.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low; ports named clk and n_rst.
REQ-005 Ports:
  clk        input   1      rising-edge system clock
  n_rst      input   1      async active-low reset
  sig_in     input   WIDTH  raw, possibly asynchronous signals; declared default '0
  en         input   1      detection enable; declared default 1'b1
  sig_sync   output  WIDTH  synchronized copy of sig_in
  rise       output  WIDTH  per-bit 1-cycle rising-edge pulse
  fall       output  WIDTH  per-bit 1-cycle falling-edge pulse
  any_edge   output  WIDTH  rise | fall
REQ-006 Instantiation connecting only clk and n_rst SHALL elaborate and run cleanly, using the input defaults.

Function
REQ-007 Each bit SHALL be processed independently, with no cross-bit interaction.
REQ-008 Synchronizer: chain of SYNC_STAGES flops per bit; sig_sync = last stage (or sig_in when SYNC_STAGES=0).
REQ-009 History flop prev SHALL load sig_sync every rising clk edge, regardless of en.
REQ-010 rise = en & sig_sync & ~prev; fall = en & ~sig_sync & prev; both combinational from flops only when SYNC_STAGES>0.
REQ-011 Latency: sig_in change stable before posedge k SHALL appear on sig_sync after posedge k+SYNC_STAGES-1, and the pulse SHALL be high for exactly one clk cycle starting there.
REQ-012 A level held for N cycles SHALL produce exactly one pulse; a constant input SHALL produce none.
REQ-013 An input pulse lasting one full cycle (sampled at one posedge only) SHALL produce one rise followed immediately by one fall on consecutive cycles.
REQ-014 Changes shorter than a clock period and not sampled SHALL produce no pulse.
REQ-015 rise and fall SHALL never be high together for the same bit.
REQ-016 en=0 SHALL force rise/fall/any_edge low without affecting sig_sync or prev; an edge occurring while en=0 is dropped, not deferred.
REQ-017 Simultaneous edges on different bits SHALL each pulse in the same cycle.

Reset
REQ-018 n_rst low SHALL immediately (asynchronously) set all sync flops and prev to RESET_VAL per bit; rise, fall, any_edge low while n_rst low (SYNC_STAGES>0).
REQ-019 After n_rst release, if sig_in equals RESET_VAL no pulse SHALL occur; if it differs, exactly one pulse SHALL occur after the REQ-011 latency.
REQ-020 Reset asserted mid-pulse SHALL terminate the pulse immediately; no pulse is regenerated from pre-reset history.

Verification
REQ-021 Reset: n_rst=0 two cycles, release on negedge, sig_in=0 -> sig_sync=0, rise=fall=0 for 10 cycles.
REQ-022 Rise latency (WIDTH=1, SYNC_STAGES=2): sig_in 0->1 before posedge k -> rise=1 only between posedge k+1 and k+2; fall=0 throughout.
REQ-023 Fall and hold: sig_in 1->0, held 20 cycles -> exactly one fall pulse, any_edge matches, no further pulses.
REQ-024 Narrow input: sig_in=1 for exactly one sampled cycle -> rise pulse then fall pulse on consecutive cycles.
REQ-025 Enable mask: en=0 during a 0->1 transition, en=1 afterwards -> no rise at any time; sig_sync still 1.
REQ-026 Multi-bit (WIDTH=4): sig_in 4'b0000->4'b1010 -> rise=4'b1010 for one cycle; asynchronous reset mid-pulse -> outputs 0 immediately.
